// File: rtl/ui_input_defs.sv
// Shared constants for the UI input conditioner read path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ui_input_defs;

  // Read-select encodings presented on rdSel
  localparam logic [1:0] RDSEL_KEYLVL  = 2'd0;
  localparam logic [1:0] RDSEL_SWLVL   = 2'd1;
  localparam logic [1:0] RDSEL_KEYSTAT = 2'd2;
  localparam logic [1:0] RDSEL_RSVD    = 2'd3;

  // Bit positions inside the key-status word
  localparam int KEYSTAT_PEND_LSB = 0;
  localparam int KEYSTAT_OVR_LSB  = 16;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, optional inversion, stability-count debounce.
// Latency: new raw level reaches 'level' 2+DEBOUNCE_CYCLES edges after first sampled.
// Backpressure: none; free-running, 'rise' is a one-cycle pre-edge strobe.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = $clog2(DEBOUNCE_CYCLES + 1),
  parameter bit RESET_VAL       = 1'b0,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync1;
  logic                sync2;
  logic                sync_val;
  logic                settle;
  logic [CNT_BITS-1:0] cnt;

  // Two-stage synchronizer; reset to the pin's idle level so no spurious event
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= RESET_VAL;
      sync2 <= RESET_VAL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign sync_val = sync2 ^ INVERT;

  // Level flips on the edge where the disagreement has lasted DEBOUNCE_CYCLES cycles
  assign settle = (sync_val != level) && (cnt == CNT_LAST);
  assign rise   = settle & sync_val;

  // Counter restarts whenever the synchronized input agrees with the accepted level
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_val == level) begin
      cnt <= '0;
    end else if (settle) begin
      level <= sync_val;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/ui_input_conditioner.sv
// Debounced KEY/SW levels with sticky, read-to-clear key press and overrun flags.
// Latency: levels/flags registered, 2+DEBOUNCE_CYCLES edges from pin; rdData combinational.
// Backpressure: none; a key-status read clears flags on the strobe edge.
module ui_input_conditioner
  import ui_input_defs::*;
#(
  parameter int DBITS           = 32,
  parameter int NKEYS           = 4,
  parameter int NSW             = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] keyRaw,
  input  logic [NSW-1:0]   swRaw,
  input  logic             rdEn,
  input  logic [1:0]       rdSel,
  output logic [DBITS-1:0] rdData,
  output logic [NKEYS-1:0] keyLevel,
  output logic [NSW-1:0]   swLevel,
  output logic [NKEYS-1:0] keyPending,
  output logic             keyIrq
);

  logic [NKEYS-1:0] key_rise;
  logic [NSW-1:0]   sw_rise_unused;
  logic [NKEYS-1:0] pending;
  logic [NKEYS-1:0] overrun;
  logic             status_clr;

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS       (CNT_BITS),
        .RESET_VAL      (1'b1),
        .INVERT         (1'b1)
      ) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (keyRaw[gi]),
        .level(keyLevel[gi]),
        .rise (key_rise[gi])
      );
    end
    for (gi = 0; gi < NSW; gi++) begin : g_sw
      debounce_bit #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_BITS       (CNT_BITS),
        .RESET_VAL      (1'b0),
        .INVERT         (1'b0)
      ) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (swRaw[gi]),
        .level(swLevel[gi]),
        .rise (sw_rise_unused[gi])
      );
    end
  endgenerate

  assign status_clr = rdEn && (rdSel == RDSEL_KEYSTAT);

  // Sticky press flags; a press coinciding with the clearing read survives as a fresh event
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      overrun <= '0;
    end else if (status_clr) begin
      pending <= key_rise;
      overrun <= '0;
    end else begin
      pending <= pending | key_rise;
      overrun <= overrun | (pending & key_rise);
    end
  end

  assign keyPending = pending;
  assign keyIrq     = |pending;

  // Read mux shows pre-clear status during the clearing cycle
  always_comb begin
    rdData = '0;
    case (rdSel)
      RDSEL_KEYLVL:  rdData[NKEYS-1:0] = keyLevel;
      RDSEL_SWLVL:   rdData[NSW-1:0]   = swLevel;
      RDSEL_KEYSTAT: begin
        rdData[KEYSTAT_PEND_LSB +: NKEYS] = pending;
        rdData[KEYSTAT_OVR_LSB  +: NKEYS] = overrun;
      end
      RDSEL_RSVD:    rdData = '0;
    endcase
  end

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Self-checking bench: directed vector table, hand-written corner sequences, random vs model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_ui_input_conditioner;

  localparam int DBITS = 32;
  localparam int NKEYS = 4;
  localparam int NSW   = 10;
  localparam int DC    = 4;
  localparam int NB    = NKEYS + NSW;

  logic             clk;
  logic             reset;
  logic [NKEYS-1:0] keyRaw;
  logic [NSW-1:0]   swRaw;
  logic             rdEn;
  logic [1:0]       rdSel;
  logic [DBITS-1:0] rdData;
  logic [NKEYS-1:0] keyLevel;
  logic [NSW-1:0]   swLevel;
  logic [NKEYS-1:0] keyPending;
  logic             keyIrq;

  int n_checks = 0;
  int n_err    = 0;

  ui_input_conditioner #(
    .DBITS(DBITS), .NKEYS(NKEYS), .NSW(NSW), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .keyRaw(keyRaw), .swRaw(swRaw),
    .rdEn(rdEn), .rdSel(rdSel), .rdData(rdData), .keyLevel(keyLevel),
    .swLevel(swLevel), .keyPending(keyPending), .keyIrq(keyIrq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Each pin reaches the filter two edges after it is sampled; the accepted level
  // flips once the last DC filter samples all disagree with it.
  bit          m_d1 [NB];
  bit          m_d2 [NB];
  bit          m_win[NB][DC];
  int          m_seen[NB];
  bit          m_lvl[NB];
  logic [3:0]  m_pend;
  logic [3:0]  m_ovr;

  function automatic bit raw_bit(int b);
    if (b < NKEYS) return keyRaw[b];
    return swRaw[b - NKEYS];
  endfunction

  task automatic model_edge();
    logic [NKEYS-1:0] rise;
    bit s;
    bit all_diff;
    if (reset) begin
      for (int b = 0; b < NB; b++) begin
        m_d1[b]   = (b < NKEYS);
        m_d2[b]   = (b < NKEYS);
        m_seen[b] = 0;
        m_lvl[b]  = 1'b0;
      end
      m_pend = '0;
      m_ovr  = '0;
    end else begin
      rise = '0;
      for (int b = 0; b < NB; b++) begin
        s       = m_d2[b] ^ (b < NKEYS);
        m_d2[b] = m_d1[b];
        m_d1[b] = raw_bit(b);
        for (int j = 0; j < DC - 1; j++) m_win[b][j] = m_win[b][j+1];
        m_win[b][DC-1] = s;
        if (m_seen[b] < DC) m_seen[b]++;
        if (m_seen[b] == DC) begin
          all_diff = 1'b1;
          for (int j = 0; j < DC; j++) if (m_win[b][j] == m_lvl[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_lvl[b] = s;
            if (b < NKEYS && s) rise[b] = 1'b1;
          end
        end
      end
      if (rdEn && rdSel == 2'd2) begin
        m_ovr  = '0;
        m_pend = rise;
      end else begin
        m_ovr  = m_ovr | (m_pend & rise);
        m_pend = m_pend | rise;
      end
    end
  endtask

  function automatic logic [3:0] m_kl();
    logic [3:0] r;
    for (int b = 0; b < NKEYS; b++) r[b] = m_lvl[b];
    return r;
  endfunction

  function automatic logic [9:0] m_sl();
    logic [9:0] r;
    for (int b = 0; b < NSW; b++) r[b] = m_lvl[NKEYS + b];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(logic [1:0] sel);
    case (sel)
      2'd0:    return {28'b0, m_kl()};
      2'd1:    return {22'b0, m_sl()};
      2'd2:    return {12'b0, m_ovr, 12'b0, m_pend};
      default: return 32'b0;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  key;
    logic [9:0]  sw;
    logic        en;
    logic [1:0]  sel;
    logic [3:0]  kl;
    logic [9:0]  sl;
    logic [3:0]  kp;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(int n, logic [3:0] k, logic [9:0] s, logic e, logic [1:0] sel,
                     logic [3:0] kl, logic [9:0] sl, logic [3:0] kp, logic [31:0] rd);
    vec_t v;
    v.key = k; v.sw = s; v.en = e; v.sel = sel;
    v.kl = kl; v.sl = sl; v.kp = kp; v.rd = rd;
    repeat (n) tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    reset  = 1'b1;
    keyRaw = 4'hF;
    swRaw  = '0;
    rdEn   = 1'b0;
    rdSel  = 2'd0;

    // Reset state
    repeat (3) tick();
    chk("rst keyLevel",   32'(keyLevel),   32'h0);
    chk("rst swLevel",    32'(swLevel),    32'h0);
    chk("rst keyPending", 32'(keyPending), 32'h0);
    chk("rst keyIrq",     32'(keyIrq),     32'h0);
    for (int s = 0; s < 4; s++) begin
      rdSel = 2'(s);
      #1;
      chk($sformatf("rst rdData sel%0d", s), rdData, 32'h0);
    end
    reset = 1'b0;
    rdSel = 2'd0;

    // Directed vectors: inputs held for one edge, outputs expected after it
    add(5, 4'hE, 10'h000, 1'b0, 2'd0, 4'h0, 10'h000, 4'h0, 32'h0);        // clean press key0
    add(1, 4'hE, 10'h000, 1'b0, 2'd0, 4'h1, 10'h000, 4'h1, 32'h1);
    add(3, 4'hC, 10'h000, 1'b0, 2'd0, 4'h1, 10'h000, 4'h1, 32'h1);        // key1 glitch
    add(4, 4'hE, 10'h000, 1'b1, 2'd0, 4'h1, 10'h000, 4'h1, 32'h1);        // sel0 reads, no effect
    add(5, 4'hE, 10'h3FF, 1'b1, 2'd1, 4'h1, 10'h000, 4'h1, 32'h0);        // switches on
    add(1, 4'hE, 10'h3FF, 1'b0, 2'd1, 4'h1, 10'h3FF, 4'h1, 32'h3FF);
    add(5, 4'hF, 10'h3FF, 1'b0, 2'd2, 4'h1, 10'h3FF, 4'h1, 32'h1);        // release key0
    add(1, 4'hF, 10'h3FF, 1'b0, 2'd2, 4'h0, 10'h3FF, 4'h1, 32'h1);
    add(5, 4'hE, 10'h3FF, 1'b0, 2'd2, 4'h0, 10'h3FF, 4'h1, 32'h1);        // second press
    add(1, 4'hE, 10'h3FF, 1'b0, 2'd2, 4'h1, 10'h3FF, 4'h1, 32'h00010001);
    add(1, 4'hE, 10'h3FF, 1'b1, 2'd3, 4'h1, 10'h3FF, 4'h1, 32'h0);        // reserved read

    foreach (tbl[i]) begin
      keyRaw = tbl[i].key;
      swRaw  = tbl[i].sw;
      rdEn   = tbl[i].en;
      rdSel  = tbl[i].sel;
      tick();
      chk($sformatf("row%0d keyLevel", i),   32'(keyLevel),   32'(tbl[i].kl));
      chk($sformatf("row%0d swLevel", i),    32'(swLevel),    32'(tbl[i].sl));
      chk($sformatf("row%0d keyPending", i), 32'(keyPending), 32'(tbl[i].kp));
      chk($sformatf("row%0d keyIrq", i),     32'(keyIrq),     32'(|tbl[i].kp));
      chk($sformatf("row%0d rdData", i),     rdData,          tbl[i].rd);
    end

    // Status read: pre-clear value visible, cleared afterwards
    rdEn  = 1'b0;
    rdSel = 2'd2;
    #1;
    chk("ovr status kept", rdData, 32'h00010001);
    rdEn = 1'b1;
    #1;
    chk("clear preread", rdData, 32'h00010001);
    tick();
    rdEn = 1'b0;
    #1;
    chk("clear postread", rdData, 32'h0);
    chk("clear keyIrq", 32'(keyIrq), 32'h0);

    // Collision: key2 press on the clearing edge with key0 pending
    keyRaw = 4'hF;
    repeat (6) tick();
    keyRaw = 4'hE;
    repeat (6) tick();
    chk("coll setup pending", 32'(keyPending), 32'h1);
    keyRaw = 4'hA;
    repeat (5) tick();
    chk("coll key2 not yet", 32'(keyLevel), 32'h1);
    rdEn = 1'b1;
    #1;
    chk("coll read", rdData, 32'h1);
    tick();
    rdEn = 1'b0;
    #1;
    chk("coll pending", 32'(keyPending), 32'h4);
    chk("coll status", rdData, 32'h4);

    // Reset two cycles after the synchronized key3 press appears
    keyRaw = 4'hF;
    repeat (6) tick();
    chk("rel levels", 32'(keyLevel), 32'h0);
    keyRaw = 4'h7;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst pending", 32'(keyPending), 32'h0);
    chk("midrst swLevel", 32'(swLevel), 32'h0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("midrst edge%0d level", c), 32'(keyLevel), 32'h0);
    end
    tick();
    chk("midrst edge6 level", 32'(keyLevel), 32'h8);
    chk("midrst edge6 pending", 32'(keyPending), 32'h8);

    // Random stimulus against the reference model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(5) == 0) begin
        k = int'($urandom_range(NKEYS - 1));
        keyRaw[k] = ~keyRaw[k];
      end
      if ($urandom_range(5) == 0) begin
        k = int'($urandom_range(NSW - 1));
        swRaw[k] = ~swRaw[k];
      end
      rdEn  = ($urandom_range(3) == 0);
      rdSel = 2'($urandom_range(3));
      reset = ($urandom_range(299) == 0);
      tick();
      chk("rnd keyLevel",   32'(keyLevel),   32'(m_kl()));
      chk("rnd swLevel",    32'(swLevel),    32'(m_sl()));
      chk("rnd keyPending", 32'(keyPending), 32'(m_pend));
      chk("rnd keyIrq",     32'(keyIrq),     32'(|m_pend));
      chk("rnd rdData",     rdData,          m_rd(rdSel));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
